// File: rtl/atm_defs_pkg.sv
// Shared definitions for the ATM keypad front-end: menu codes, key codes and FSM states.
package atm_defs_pkg;

  localparam logic [2:0] BALANCE               = 3'd3;
  localparam logic [2:0] WITHDRAW              = 3'd4;
  localparam logic [2:0] WITHDRAW_SHOW_BALANCE = 3'd5;
  localparam logic [2:0] TRANSACTION           = 3'd6;
  localparam logic [2:0] EXIT                  = 3'd7;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIN_ENTRY,
    ST_MENU_SELECT,
    ST_DEST_ENTRY,
    ST_AMOUNT_ENTRY,
    ST_ISSUE,
    ST_EXIT_PULSE
  } fe_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_decimal_accumulator.sv
// Decimal entry accumulator: acc = acc*10 + digit, limited to four digits.
module atm_decimal_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic [13:0] acc
);

  logic [2:0] ndig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      ndig <= '0;
    end else if (clr) begin
      acc  <= '0;
      ndig <= '0;
    end else if (digit_valid && (ndig < 3'd4)) begin
      // four digits top out at 9999, so 14 bits never wrap
      acc  <= (acc << 3) + (acc << 1) + {10'd0, digit};
      ndig <= ndig + 3'd1;
    end
  end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad/card session front-end producing held commands for the ATM controller.
//
// state           | meaning
// ST_IDLE         | no session, waiting for card insertion edge
// ST_PIN_ENTRY    | collecting PIN digit, ENTER confirms
// ST_MENU_SELECT  | waiting for menu digit
// ST_DEST_ENTRY   | accumulating destination account
// ST_AMOUNT_ENTRY | accumulating amount
// ST_ISSUE        | command held with cmdValid until cmdReady
// ST_EXIT_PULSE   | one-cycle exit, session registers cleared
module atm_keypad_frontend
  import atm_defs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int AMT_MAX        = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cardInserted,
  input  logic [11:0] cardAccNumber,
  input  logic        keyValid,
  input  logic [3:0]  keyCode,
  input  logic        cmdReady,
  output logic [11:0] accNumber,
  output logic [3:0]  pin,
  output logic [2:0]  menuOption,
  output logic [10:0] amount,
  output logic [11:0] destinationAccNumber,
  output logic        cmdValid,
  output logic        exit,
  output logic        entryError,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  fe_state_t state, nxt;

  logic [13:0]   acc;
  logic [TW-1:0] tmr;
  logic          card_q;
  logic          pin_ok;

  logic key_dig, key_enter, key_clear, key_cancel;
  logic tmr_run, timed_out, abort;
  logic ld_card, ld_pin, ld_menu, ld_dest, ld_amt, clr_amt, clr_all, err;
  logic acc_clr, acc_dig;

  assign key_dig    = keyValid && is_digit(keyCode);
  assign key_enter  = keyValid && (keyCode == KEY_ENTER);
  assign key_clear  = keyValid && (keyCode == KEY_CLEAR);
  assign key_cancel = keyValid && (keyCode == KEY_CANCEL);

  assign tmr_run   = (state == ST_PIN_ENTRY) || (state == ST_MENU_SELECT) ||
                     (state == ST_DEST_ENTRY) || (state == ST_AMOUNT_ENTRY);
  assign timed_out = tmr_run && (tmr == '0) && !keyValid;
  assign abort     = (state != ST_IDLE) && (state != ST_EXIT_PULSE) &&
                     (key_cancel || !cardInserted || timed_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    ld_card = 1'b0;
    ld_pin  = 1'b0;
    ld_menu = 1'b0;
    ld_dest = 1'b0;
    ld_amt  = 1'b0;
    clr_amt = 1'b0;
    clr_all = 1'b0;
    err     = 1'b0;
    acc_clr = 1'b0;
    acc_dig = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cardInserted && !card_q) begin
          ld_card = 1'b1;
          nxt     = ST_PIN_ENTRY;
        end
      end
      ST_PIN_ENTRY: begin
        if (key_dig) ld_pin = 1'b1;
        else if (key_enter) begin
          if (pin_ok) nxt = ST_MENU_SELECT;
          else        err = 1'b1;
        end
      end
      ST_MENU_SELECT: begin
        acc_clr = 1'b1;
        if (key_dig && !keyCode[3]) begin
          case (keyCode[2:0])
            BALANCE: begin
              ld_menu = 1'b1;
              nxt     = ST_ISSUE;
            end
            WITHDRAW, WITHDRAW_SHOW_BALANCE: begin
              ld_menu = 1'b1;
              nxt     = ST_AMOUNT_ENTRY;
            end
            TRANSACTION: begin
              ld_menu = 1'b1;
              nxt     = ST_DEST_ENTRY;
            end
            EXIT:    nxt = ST_EXIT_PULSE;
            default: ;
          endcase
        end
      end
      ST_DEST_ENTRY: begin
        acc_dig = key_dig;
        if (key_clear) acc_clr = 1'b1;
        else if (key_enter) begin
          acc_clr = 1'b1;
          if ((acc != '0) && (acc <= 14'd4095) && (acc[11:0] != accNumber)) begin
            ld_dest = 1'b1;
            nxt     = ST_AMOUNT_ENTRY;
          end else begin
            err = 1'b1;
          end
        end
      end
      ST_AMOUNT_ENTRY: begin
        acc_dig = key_dig;
        if (key_clear) acc_clr = 1'b1;
        else if (key_enter) begin
          if ((acc != '0) && (acc <= 14'(AMT_MAX))) begin
            ld_amt = 1'b1;
            nxt    = ST_ISSUE;
          end else begin
            err     = 1'b1;
            acc_clr = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cmdReady) begin
          clr_amt = 1'b1;
          acc_clr = 1'b1;
          nxt     = ST_MENU_SELECT;
        end
      end
      ST_EXIT_PULSE: begin
        clr_all = 1'b1;
        acc_clr = 1'b1;
        nxt     = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    // cancel, card removal and timeout override whatever the state decided
    if (abort) begin
      nxt = ST_EXIT_PULSE;
      err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accNumber            <= '0;
      pin                  <= '0;
      pin_ok               <= 1'b0;
      menuOption           <= '0;
      amount               <= '0;
      destinationAccNumber <= '0;
      entryError           <= 1'b0;
      card_q               <= 1'b0;
      tmr                  <= TMR_LOAD;
    end else begin
      card_q     <= cardInserted;
      entryError <= err;
      if (!tmr_run || keyValid) tmr <= TMR_LOAD;
      else if (tmr != '0)       tmr <= tmr - TW'(1);
      if (clr_all) begin
        accNumber            <= '0;
        pin                  <= '0;
        pin_ok               <= 1'b0;
        menuOption           <= '0;
        amount               <= '0;
        destinationAccNumber <= '0;
      end else begin
        if (ld_card) accNumber <= cardAccNumber;
        if (ld_pin) begin
          pin    <= keyCode;
          pin_ok <= 1'b1;
        end
        if (ld_menu) menuOption <= keyCode[2:0];
        if (ld_dest) destinationAccNumber <= acc[11:0];
        if (ld_amt)       amount <= acc[10:0];
        else if (clr_amt) amount <= '0;
      end
    end
  end

  atm_decimal_accumulator u_acc (
    .clk         (clk),
    .rst         (rst),
    .clr         (acc_clr),
    .digit_valid (acc_dig),
    .digit       (keyCode),
    .acc         (acc)
  );

  assign cmdValid = (state == ST_ISSUE);
  assign exit     = (state == ST_EXIT_PULSE);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend with hand-computed expectations.
module tb_atm_keypad_frontend;
  import atm_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cardInserted;
  logic [11:0] cardAccNumber;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        cmdReady;
  logic [11:0] accNumber;
  logic [3:0]  pin;
  logic [2:0]  menuOption;
  logic [10:0] amount;
  logic [11:0] destinationAccNumber;
  logic        cmdValid;
  logic        exit;
  logic        entryError;
  logic        busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  atm_keypad_frontend #(.TIMEOUT_CYCLES(16), .AMT_MAX(2047)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cardInserted         (cardInserted),
    .cardAccNumber        (cardAccNumber),
    .keyValid             (keyValid),
    .keyCode              (keyCode),
    .cmdReady             (cmdReady),
    .accNumber            (accNumber),
    .pin                  (pin),
    .menuOption           (menuOption),
    .amount               (amount),
    .destinationAccNumber (destinationAccNumber),
    .cmdValid             (cmdValid),
    .exit                 (exit),
    .entryError           (entryError),
    .busy                 (busy)
  );

  wire [45:0] all_out = {accNumber, pin, menuOption, amount, destinationAccNumber,
                         cmdValid, exit, entryError, busy};

  // called at a negedge; returns at the next negedge with the key consumed
  task automatic key(input logic [3:0] c);
    keyValid = 1'b1;
    keyCode  = c;
    @(negedge clk);
    keyValid = 1'b0;
    keyCode  = 4'h0;
  endtask

  task automatic new_card();
    cardInserted = 1'b0;
    @(negedge clk);
    cardInserted = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cardInserted = 1'b0; cardAccNumber = '0;
    keyValid = 1'b0; keyCode = '0; cmdReady = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (all_out !== 46'd0) $display("FAIL reset_outputs got=%h exp=0", all_out);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dut.state !== ST_IDLE || busy !== 1'b0)
      $display("FAIL reset_idle state=%0d busy=%b exp state=%0d busy=0", dut.state, busy, ST_IDLE);
    else passed++;
  endtask

  task automatic test_withdraw();
    cmdReady = 1'b1;
    cardAccNumber = 12'd2178;
    cardInserted = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || accNumber !== 12'd2178)
      $display("FAIL card_latch busy=%b acc=%0d exp busy=1 acc=2178", busy, accNumber);
    else passed++;
    key(4'd4);
    total++;
    if (pin !== 4'd4) $display("FAIL pin_latch got=%0d exp=4", pin);
    else passed++;
    key(KEY_ENTER);
    key(4'd5);
    total++;
    if (menuOption !== 3'd5 || dut.state !== ST_AMOUNT_ENTRY)
      $display("FAIL menu_withdraw menu=%0d state=%0d exp menu=5 state=%0d", menuOption, dut.state, ST_AMOUNT_ENTRY);
    else passed++;
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    total++;
    if (cmdValid !== 1'b0) $display("FAIL early_valid got=%b exp=0", cmdValid);
    else passed++;
    key(KEY_ENTER);
    total++;
    if ({cmdValid, accNumber, pin, menuOption, amount} !== {1'b1, 12'd2178, 4'd4, 3'd5, 11'd1000})
      $display("FAIL withdraw_cmd valid=%b acc=%0d pin=%0d menu=%0d amt=%0d exp 1/2178/4/5/1000",
               cmdValid, accNumber, pin, menuOption, amount);
    else passed++;
    @(negedge clk);
    total++;
    if (cmdValid !== 1'b0 || dut.state !== ST_MENU_SELECT || amount !== 11'd0)
      $display("FAIL withdraw_handshake valid=%b state=%0d amt=%0d exp 0/%0d/0", cmdValid, dut.state, amount, ST_MENU_SELECT);
    else passed++;
  endtask

  task automatic test_overflow();
    key(4'd4);
    key(4'd2); key(4'd5); key(4'd0); key(4'd0);
    key(KEY_ENTER);
    total++;
    if (entryError !== 1'b1 || cmdValid !== 1'b0)
      $display("FAIL amount_overflow err=%b valid=%b exp err=1 valid=0", entryError, cmdValid);
    else passed++;
    key(4'd9);
    total++;
    if (entryError !== 1'b0) $display("FAIL err_one_cycle got=%b exp=0", entryError);
    else passed++;
    key(4'd9); key(4'd9);
    key(KEY_ENTER);
    total++;
    if (cmdValid !== 1'b1 || amount !== 11'd999 || menuOption !== 3'd4)
      $display("FAIL amount_999 valid=%b amt=%0d menu=%0d exp 1/999/4", cmdValid, amount, menuOption);
    else passed++;
    @(negedge clk);
    total++;
    if (cmdValid !== 1'b0) $display("FAIL overflow_handshake got=%b exp=0", cmdValid);
    else passed++;
  endtask

  task automatic test_transfer();
    logic stable;
    cmdReady = 1'b0;
    key(4'd6);
    key(4'd2); key(4'd8); key(4'd1); key(4'd6); key(4'd9);
    key(KEY_ENTER);
    total++;
    if (destinationAccNumber !== 12'd2816 || dut.state !== ST_AMOUNT_ENTRY)
      $display("FAIL dest_5th_digit dest=%0d state=%0d exp 2816/%0d", destinationAccNumber, dut.state, ST_AMOUNT_ENTRY);
    else passed++;
    key(4'd7); key(4'd7); key(KEY_CLEAR);
    key(4'd5); key(4'd0); key(4'd0);
    key(KEY_ENTER);
    total++;
    if ({cmdValid, destinationAccNumber, amount, menuOption} !== {1'b1, 12'd2816, 11'd500, 3'd6})
      $display("FAIL transfer_cmd valid=%b dest=%0d amt=%0d menu=%0d exp 1/2816/500/6",
               cmdValid, destinationAccNumber, amount, menuOption);
    else passed++;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({cmdValid, destinationAccNumber, amount, menuOption, accNumber, pin} !==
          {1'b1, 12'd2816, 11'd500, 3'd6, 12'd2178, 4'd4}) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1) $display("FAIL hold_stable got=%b exp=1", stable);
    else passed++;
    cmdReady = 1'b1;
    @(negedge clk);
    cmdReady = 1'b0;
    total++;
    if (cmdValid !== 1'b0 || amount !== 11'd0 || dut.state !== ST_MENU_SELECT)
      $display("FAIL transfer_handshake valid=%b amt=%0d state=%0d exp 0/0/%0d", cmdValid, amount, dut.state, ST_MENU_SELECT);
    else passed++;
  endtask

  task automatic test_reject_and_cancel();
    key(4'd6);
    key(4'd2); key(4'd1); key(4'd7); key(4'd8);
    key(KEY_ENTER);
    total++;
    if (entryError !== 1'b1 || dut.state !== ST_DEST_ENTRY)
      $display("FAIL dest_equals_own err=%b state=%0d exp 1/%0d", entryError, dut.state, ST_DEST_ENTRY);
    else passed++;
    key(4'd0);
    key(KEY_ENTER);
    total++;
    if (entryError !== 1'b1) $display("FAIL dest_zero err=%b exp=1", entryError);
    else passed++;
    key(4'd3); key(4'd0); key(4'd0); key(4'd0);
    key(KEY_ENTER);
    key(4'd2); key(4'd0); key(4'd4); key(4'd8);
    key(KEY_ENTER);
    total++;
    if (entryError !== 1'b1 || cmdValid !== 1'b0 || destinationAccNumber !== 12'd3000)
      $display("FAIL amount_2048 err=%b valid=%b dest=%0d exp 1/0/3000", entryError, cmdValid, destinationAccNumber);
    else passed++;
    key(4'd2); key(4'd0); key(4'd4); key(4'd7);
    key(KEY_ENTER);
    total++;
    if (cmdValid !== 1'b1 || amount !== 11'd2047)
      $display("FAIL amount_max valid=%b amt=%0d exp 1/2047", cmdValid, amount);
    else passed++;
    key(KEY_CANCEL);
    total++;
    if (cmdValid !== 1'b0 || exit !== 1'b1 || busy !== 1'b1)
      $display("FAIL cancel_issue valid=%b exit=%b busy=%b exp 0/1/1", cmdValid, exit, busy);
    else passed++;
    @(negedge clk);
    total++;
    if (all_out !== 46'd0) $display("FAIL cancel_cleared got=%h exp=0", all_out);
    else passed++;
  endtask

  task automatic test_timeout();
    logic early;
    new_card();
    key(KEY_ENTER);
    total++;
    if (entryError !== 1'b1) $display("FAIL pin_missing err=%b exp=1", entryError);
    else passed++;
    key(4'd4);
    key(KEY_ENTER);
    early = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (exit !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) $display("FAIL timeout_early got=%b exp=0", early);
    else passed++;
    @(negedge clk);
    total++;
    if (exit !== 1'b1) $display("FAIL timeout_exit got=%b exp=1", exit);
    else passed++;
    @(negedge clk);
    total++;
    if (all_out !== 46'd0) $display("FAIL timeout_cleared got=%h exp=0", all_out);
    else passed++;
  endtask

  task automatic test_card_removal();
    new_card();
    key(4'd4);
    cardInserted = 1'b0;
    @(negedge clk);
    total++;
    if (exit !== 1'b1) $display("FAIL card_removed_exit got=%b exp=1", exit);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || exit !== 1'b0) $display("FAIL card_removed_idle busy=%b exit=%b exp 0/0", busy, exit);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic saw_exit;
    new_card();
    key(4'd4); key(KEY_ENTER); key(4'd4); key(4'd1); key(4'd2);
    total++;
    if (dut.state !== ST_AMOUNT_ENTRY) $display("FAIL pre_reset_state got=%0d exp=%0d", dut.state, ST_AMOUNT_ENTRY);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (all_out !== 46'd0 || dut.state !== ST_IDLE)
      $display("FAIL async_reset out=%h state=%0d exp 0/%0d", all_out, dut.state, ST_IDLE);
    else passed++;
    cardInserted = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_exit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (exit !== 1'b0 || busy !== 1'b0) saw_exit = 1'b1;
    end
    total++;
    if (saw_exit !== 1'b0) $display("FAIL reset_no_exit got=%b exp=0", saw_exit);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_withdraw();
    test_overflow();
    test_transfer();
    test_reject_and_cancel();
    test_timeout();
    test_card_removal();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
